// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: feeds one operand bit pair per cycle to a shared
// external 1-bit full adder, LSB first, and returns the assembled WIDTH-bit sum.
module serial_add_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             c_init,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_c,
  input  logic             fa_sum,
  input  logic             fa_carry,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_carry,
  output logic             busy
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_sh;
  logic             carry_q;
  logic [CW-1:0]    cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      a_sh    <= '0;
      b_sh    <= '0;
      sum_sh  <= '0;
      carry_q <= 1'b0;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh    <= op_a;
            b_sh    <= op_b;
            carry_q <= c_init;
            sum_sh  <= '0;
            cnt     <= '0;
            state   <= RUN;
          end
        end
        RUN: begin
          // Sum bits enter at the MSB so bit 0 lands at position 0 after WIDTH shifts
          sum_sh  <= {fa_sum, sum_sh[WIDTH-1:1]};
          carry_q <= fa_carry;
          a_sh    <= a_sh >> 1;
          b_sh    <= b_sh >> 1;
          if (cnt == LAST) begin
            state <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    in_ready  = (state == IDLE) && !rst;
    busy      = (state == RUN) || (state == DONE);
    out_valid = (state == DONE);
    fa_a      = 1'b0;
    fa_b      = 1'b0;
    fa_c      = 1'b0;
    out_sum   = '0;
    out_carry = 1'b0;
    if (state == RUN) begin
      fa_a = a_sh[0];
      fa_b = b_sh[0];
      fa_c = carry_q;
    end
    if (state == DONE) begin
      out_sum   = sum_sh;
      out_carry = carry_q;
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed and random bench for serial_add_ctrl with a behavioural full adder
// and a scoreboard of expected {carry,sum} results in issue order.
module tb_serial_add_ctrl;

  localparam int unsigned W = 8;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         c_init;
  logic         fa_a;
  logic         fa_b;
  logic         fa_c;
  logic         fa_sum;
  logic         fa_carry;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_carry;
  logic         busy;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .c_init(c_init),
    .fa_a(fa_a), .fa_b(fa_b), .fa_c(fa_c),
    .fa_sum(fa_sum), .fa_carry(fa_carry),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_carry(out_carry), .busy(busy)
  );

  // The shared full-adder cell
  assign fa_sum   = fa_a ^ fa_b ^ fa_c;
  assign fa_carry = (fa_a & fa_b) | (fa_c & (fa_a ^ fa_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W:0] exp;
    int         t0;
  } item_t;

  item_t        sb[$];
  int           acc_q[$];
  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  int           n_out = 0;
  int           ridx = 0;
  logic [W-1:0] ma;
  logic [W-1:0] mb;
  logic         mc;
  logic         prev_ov = 1'b0;
  logic         rnd = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Monitor: invariants, bit-serial model of the adder drive, scoreboard
  always @(negedge clk) begin
    if (rst) begin
      ridx    = 0;
      prev_ov = 1'b0;
    end else begin
      chk("ready_valid_excl", 64'(in_ready && out_valid), 64'd0);
      chk("busy_vs_ready", 64'(busy), 64'(!in_ready));
      if (!out_valid) chk("out_zero_when_invalid", 64'({out_carry, out_sum}), 64'd0);
      if (!busy || out_valid) begin
        chk("fa_idle_zero", 64'({fa_a, fa_b, fa_c}), 64'd0);
      end else if (ridx < W) begin
        chk("fa_a_bit", 64'(fa_a), 64'(ma[ridx]));
        chk("fa_b_bit", 64'(fa_b), 64'(mb[ridx]));
        chk("fa_c_carry", 64'(fa_c), 64'(mc));
        mc   = (ma[ridx] & mb[ridx]) | (mc & (ma[ridx] ^ mb[ridx]));
        ridx = ridx + 1;
      end else begin
        chk("run_overlong", 64'(ridx), 64'(W - 1));
      end
      if (out_valid && !prev_ov) begin
        chk("run_length", 64'(ridx), 64'(W));
        if (sb.size() == 0) chk("spurious_valid", 64'(out_valid), 64'd0);
        else chk("latency", 64'(cyc), 64'(sb[0].t0 + W));
      end
      if (out_valid && out_ready) begin
        n_out++;
        if (sb.size() == 0) begin
          chk("unexpected_result", 64'(out_valid), 64'd0);
        end else begin
          item_t it;
          it = sb.pop_front();
          chk("result", 64'({out_carry, out_sum}), 64'(it.exp));
        end
      end
      if (in_valid && in_ready) begin
        item_t it;
        it.exp = {1'b0, op_a} + {1'b0, op_b} + {{W{1'b0}}, c_init};
        it.t0  = cyc + 1;
        sb.push_back(it);
        acc_q.push_back(cyc + 1);
        ma   = op_a;
        mb   = op_b;
        mc   = c_init;
        ridx = 0;
      end
      prev_ov = out_valid;
    end
  end

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    int  n;
    logic ok;
    op_a     = a;
    op_b     = b;
    c_init   = c;
    in_valid = 1'b1;
    n = 0;
    forever begin
      ok = in_ready;
      @(posedge clk);
      #1;
      if (rnd) out_ready = ($urandom_range(0, 3) != 0);
      if (ok) break;
      n++;
      if (n > 200) begin
        chk("accept_timeout", 64'(n), 64'd0);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(posedge clk);
      #1;
      if (rnd) out_ready = ($urandom_range(0, 3) != 0);
      n++;
    end
    chk("drain_timeout", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    int n;
    int outs;
    rst = 1'b1; in_valid = 1'b0; op_a = '0; op_b = '0; c_init = 1'b0; out_ready = 1'b1;
    #2;
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_outputs", 64'({busy, out_carry, out_sum, fa_a, fa_b, fa_c}), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1 chk("in_ready_after_rst", 64'(in_ready), 64'd1);

    // Basic add and full carry ripple
    send(8'h5A, 8'h3C, 1'b0);
    drain();
    send(8'hFF, 8'h01, 1'b0);
    drain();

    // Back-to-back with in_valid held high
    acc_q.delete();
    op_a = 8'hFF; op_b = 8'hFF; c_init = 1'b1; in_valid = 1'b1;
    n = 0;
    while (acc_q.size() < 2 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    chk("b2b_accepts", 64'(acc_q.size()), 64'd2);
    if (acc_q.size() >= 2) chk("issue_interval", 64'(acc_q[1] - acc_q[0]), 64'(W + 2));
    drain();

    // Stalled result must stay stable; new operands ignored meanwhile
    out_ready = 1'b0;
    send(8'h81, 8'h90, 1'b1);
    n = 0;
    while (!out_valid && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    outs = n_out;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        in_valid = 1'b1;
        op_a = 8'h33;
      end
      chk("stall_valid", 64'(out_valid), 64'd1);
      chk("stall_data", 64'({out_carry, out_sum}), 64'h112);
      chk("stall_in_ready", 64'(in_ready), 64'd0);
      @(posedge clk);
      #1;
      op_a = op_a + 8'h11;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("retire_first_ready", 64'(out_valid), 64'd0);
    chk("retire_count", 64'(n_out - outs), 64'd1);
    chk("idle_after_retire", 64'(in_ready), 64'd1);
    drain();

    // Asynchronous reset on RUN cycle 3
    send(8'h12, 8'h34, 1'b0);
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("arst_in_ready", 64'(in_ready), 64'd0);
    chk("arst_outputs", 64'({out_valid, busy, out_carry, out_sum, fa_a, fa_b, fa_c}), 64'd0);
    sb.delete();
    outs = n_out;
    @(posedge clk);
    #1 rst = 1'b0;
    #1 chk("arst_release_ready", 64'(in_ready), 64'd1);
    repeat (12) @(posedge clk);
    #1 chk("arst_no_result", 64'(n_out - outs), 64'd0);
    send(8'h12, 8'h34, 1'b0);
    drain();

    // Random ops with random consumer back-pressure
    rnd = 1'b1;
    for (int i = 0; i < 200; i++) begin
      send(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));
    end
    drain();
    rnd = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
